uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio_pkg.sv | 37 +++
 rtl/uart_tx_mmio_fifo.sv | 72 +++++++
 rtl/uart_tx_mmio.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and the serialiser state encoding.
package uart_tx_mmio_pkg;

  // Register offsets within the 4-byte window (address[1:0])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS register bit positions
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_OVF_BIT   = 3;

  // Serialiser states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Assemble the STATUS byte; the upper nibble always reads zero
  function automatic logic [7:0] status_byte(input logic busy, input logic full,
                                             input logic empty, input logic ovf);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_BUSY_BIT]  = busy;
    s[STAT_FULL_BIT]  = full;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_OVF_BIT]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter. A push while full is only
// taken when a pop on the same edge frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Flag decode, accept qualification and read port
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    dout      = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next pointer values; both wrap naturally modulo 2*DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because empty gates every read
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: 4-byte register window, byte FIFO and
// a serialiser whose bit period is DIV+1 clocks.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [7:0] BASE    = 8'hF0,
  parameter int         DEPTH   = 4,
  parameter logic [7:0] DIV_RST = 8'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] address,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       hit,
  output logic       tx,
  output logic       irq
);

  tx_state_e  state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       irq_q, irq_d;
  logic [7:0] div_q, div_d;
  logic       enable_q, enable_d;
  logic       overflow_q, overflow_d;

  logic [1:0] offset_s;
  logic       wr_en_s;
  logic       push_s;
  logic       pop_s;
  logic       ovf_clr_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic [7:0] fifo_dout_s;
  logic       unused_read_s;

  // Reads carry no side effects, so the strobe is deliberately not consumed
  assign unused_read_s = read;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .din  (wdata),
    .dout (fifo_dout_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  // Address decode and bus strobes
  always_comb begin
    hit       = (address[7:2] == BASE[7:2]);
    offset_s  = address[1:0];
    wr_en_s   = write && hit;
    push_s    = wr_en_s && (offset_s == REG_DATA);
    ovf_clr_s = wr_en_s && (offset_s == REG_STATUS) && wdata[STAT_OVF_BIT];
    pop_s     = (state_q == TX_IDLE) && enable_q && !fifo_empty_s;
  end

  // Combinational read mux; zero outside the window
  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      case (offset_s)
        REG_DATA:   rdata = 8'h00;
        REG_STATUS: rdata = status_byte(state_q != TX_IDLE, fifo_full_s,
                                        fifo_empty_s, overflow_q);
        REG_DIV:    rdata = div_q;
        REG_CTRL:   rdata = {7'b0000000, enable_q};
        default:    rdata = 8'h00;
      endcase
    end else begin
      rdata = 8'h00;
    end
  end

  // Control register updates and the sticky overflow flag
  always_comb begin
    div_d      = div_q;
    enable_d   = enable_q;
    overflow_d = overflow_q;
    if (wr_en_s && (offset_s == REG_DIV)) begin
      div_d = wdata;
    end else begin
      div_d = div_q;
    end
    if (wr_en_s && (offset_s == REG_CTRL)) begin
      enable_d = wdata[0];
    end else begin
      enable_d = enable_q;
    end
    // A push that finds the FIFO full with no pop alongside is lost
    if (push_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Serialiser next state; DIV is sampled only at each baud reload
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      TX_IDLE: begin
        if (pop_s) begin
          state_d = TX_START;
          shift_d = fifo_dout_s;
          baud_d  = div_q;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (baud_q == 8'd0) begin
          state_d = TX_DATA;
          baud_d  = div_q;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q - 8'd1;
        end
      end
      TX_DATA: begin
        if (baud_q == 8'd0) begin
          baud_d  = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 8'd1;
        end
      end
      TX_STOP: begin
        if (baud_q == 8'd0) begin
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q - 8'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Line level and interrupt, both registered from the current state
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_q[0];
      TX_STOP:  tx_d = 1'b1;
      TX_IDLE:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    irq_d = fifo_empty_s && (state_q == TX_IDLE);
  end

  // All block state; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      baud_q     <= 8'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b0;
      div_q      <= DIV_RST;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
      div_q      <= div_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed plus randomized bench for uart_tx_mmio. The line is sampled on
// every falling clock edge and compared with a waveform built from the byte,
// the bit period and the 8N1 framing rules.
module tb_uart_tx_mmio;

  logic       clk;
  logic       rst;
  logic       write;
  logic       read;
  logic [7:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       hit;
  logic       tx;
  logic       irq;

  int total;
  int bad;
  bit exp_wave[$];
  bit last_cap[$];
  logic [7:0] exp_q[$];
  logic [7:0] rd_v;
  logic [7:0] dec_v;
  logic [7:0] byte_v;
  int div_v;
  int n_v;
  int lows_v;
  int mism_v;
  bit to_v;

  uart_tx_mmio dut (
    .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
    .wdata(wdata), .rdata(rdata), .hit(hit), .tx(tx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each bus task starts and ends on a falling edge and spans one clock
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    address = a; wdata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    address = a; read = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic hit_chk(input string tag, input logic [7:0] a, input logic exp_hit);
    address = a;
    #1;
    chk({tag, "_hit"}, hit, exp_hit);
    if (!exp_hit) chk({tag, "_rd"}, rdata, 8'h00);
    @(negedge clk);
  endtask

  // 8N1 line image: start, LSB-first data, stop, each p samples long
  function automatic void build_wave(input logic [7:0] b, input int p);
    exp_wave.delete();
    for (int i = 0; i < p; i++) exp_wave.push_back(1'b0);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < p; i++) exp_wave.push_back(b[j]);
    for (int i = 0; i < p; i++) exp_wave.push_back(1'b1);
  endfunction

  // Wait (bounded) for a start bit, then capture and compare exp_wave
  task automatic capture(input string tag);
    bit to;
    int mism;
    to = 1'b1;
    mism = 0;
    last_cap.delete();
    for (int i = 0; i < 4000; i++) begin
      if (tx === 1'b0) begin to = 1'b0; break; end
      @(negedge clk);
    end
    chk({tag, "_start_seen"}, to, 1'b0);
    if (!to) begin
      for (int k = 0; k < exp_wave.size(); k++) begin
        if (k > 0) @(negedge clk);
        last_cap.push_back(tx);
        if (tx !== exp_wave[k]) mism++;
      end
    end else begin
      mism = exp_wave.size();
    end
    chk({tag, "_wave_mism"}, mism, 0);
  endtask

  task automatic capture_frame(input string tag, input logic [7:0] b, input int p);
    logic [7:0] d;
    build_wave(b, p);
    capture(tag);
    d = 8'h00;
    if (last_cap.size() == 10 * p)
      for (int i = 0; i < 8; i++) d[i] = last_cap[(i + 1) * p + p / 2];
    chk({tag, "_byte"}, d, b);
  endtask

  task automatic count_lows(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) c++;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; write = 1'b0; read = 1'b0; address = 8'h00; wdata = 8'h00;
    @(negedge clk); @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_irq", irq, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("irq_after_rst", irq, 1'b1);

    // Register map after reset and window decode
    rd_chk("rst_data", 8'hF0, 8'h00);
    rd_chk("rst_status", 8'hF1, 8'h04);
    rd_chk("rst_div", 8'hF2, 8'h09);
    rd_chk("rst_ctrl", 8'hF3, 8'h00);
    hit_chk("addr_ef", 8'hEF, 1'b0);
    hit_chk("addr_f4", 8'hF4, 1'b0);
    hit_chk("addr_f3", 8'hF3, 1'b1);

    // Single frame: push-to-start latency and exact line image
    bus_write(8'hF2, 8'h03);
    bus_write(8'hF3, 8'h01);
    bus_write(8'hF0, 8'hA5);
    chk("lat_edge1", tx, 1'b1);
    @(negedge clk);
    chk("lat_edge2", tx, 1'b1);
    @(negedge clk);
    chk("lat_fall", tx, 1'b0);
    capture_frame("a5", 8'hA5, 4);
    @(negedge clk);
    rd_chk("status_after_a5", 8'hF1, 8'h04);
    chk("irq_idle", irq, 1'b1);

    // Busy status mid-frame; clearing enable lets the frame finish only
    bus_write(8'hF3, 8'h00);
    bus_write(8'hF0, 8'h11);
    bus_write(8'hF0, 8'h22);
    bus_write(8'hF3, 8'h01);
    @(negedge clk); @(negedge clk);
    rd_chk("status_mid", 8'hF1, 8'h01);
    chk("irq_busy", irq, 1'b0);
    bus_write(8'hF3, 8'h00);
    rd_v = 8'hFF;
    for (int i = 0; i < 200; i++) begin
      bus_read(8'hF1, rd_v);
      if (rd_v[0] == 1'b0) break;
    end
    chk("status_disabled_idle", rd_v, 8'h00);
    count_lows(30, lows_v);
    chk("no_pop_when_disabled", lows_v, 0);
    bus_write(8'hF3, 8'h01);
    capture_frame("b22", 8'h22, 4);
    @(negedge clk);
    rd_chk("status_after_22", 8'hF1, 8'h04);

    // Overflow: five pushes into four slots, sticky flag, W1C clear
    bus_write(8'hF3, 8'h00);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      byte_v = 8'($urandom);
      if (exp_q.size() < 4) exp_q.push_back(byte_v);
      bus_write(8'hF0, byte_v);
    end
    rd_chk("status_ovf", 8'hF1, 8'h0A);
    bus_write(8'hF1, 8'h08);
    rd_chk("status_ovf_clr", 8'hF1, 8'h02);
    bus_write(8'hF3, 8'h01);
    while (exp_q.size() > 0) capture_frame("ovf_frame", exp_q.pop_front(), 4);
    count_lows(60, lows_v);
    chk("fifth_byte_absent", lows_v, 0);
    rd_chk("status_ovf_done", 8'hF1, 8'h04);

    // Full FIFO: enable, then push on the edge that pops the head
    bus_write(8'hF3, 8'h00);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      byte_v = 8'($urandom);
      exp_q.push_back(byte_v);
      bus_write(8'hF0, byte_v);
    end
    rd_chk("status_full", 8'hF1, 8'h02);
    bus_write(8'hF3, 8'h01);
    byte_v = 8'($urandom);
    exp_q.push_back(byte_v);
    bus_write(8'hF0, byte_v);
    while (exp_q.size() > 0) capture_frame("pp_frame", exp_q.pop_front(), 4);
    @(negedge clk);
    rd_chk("status_pp_no_ovf", 8'hF1, 8'h04);

    // Randomized rounds: random divider and burst length
    for (int r = 0; r < 3; r++) begin
      div_v = $urandom_range(1, 5);
      n_v = $urandom_range(1, 6);
      bus_write(8'hF3, 8'h00);
      bus_write(8'hF2, 8'(div_v));
      exp_q.delete();
      for (int i = 0; i < n_v; i++) begin
        byte_v = 8'($urandom);
        if (exp_q.size() < 4) exp_q.push_back(byte_v);
        bus_write(8'hF0, byte_v);
      end
      rd_chk("rnd_status", 8'hF1,
             {4'b0000, (n_v > 4) ? 1'b1 : 1'b0, 1'b0, (n_v >= 4) ? 1'b1 : 1'b0, 1'b0});
      bus_write(8'hF1, 8'h08);
      bus_write(8'hF3, 8'h01);
      while (exp_q.size() > 0) capture_frame("rnd_frame", exp_q.pop_front(), div_v + 1);
      @(negedge clk);
      rd_chk("rnd_status_done", 8'hF1, 8'h04);
    end

    // Divider change during data bit 0: that bit keeps 4 clocks, rest take 2
    bus_write(8'hF2, 8'h03);
    bus_write(8'hF3, 8'h01);
    byte_v = 8'($urandom);
    bus_write(8'hF0, byte_v);
    exp_wave.delete();
    for (int i = 0; i < 4; i++) exp_wave.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_wave.push_back(byte_v[0]);
    for (int j = 1; j < 8; j++)
      for (int i = 0; i < 2; i++) exp_wave.push_back(byte_v[j]);
    for (int i = 0; i < 2; i++) exp_wave.push_back(1'b1);
    to_v = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (tx === 1'b0) begin to_v = 1'b0; break; end
      @(negedge clk);
    end
    chk("divchg_start_seen", to_v, 1'b0);
    mism_v = 0;
    address = 8'hF2; wdata = 8'h01;
    for (int k = 0; k < exp_wave.size(); k++) begin
      if (k > 0) @(negedge clk);
      if (tx !== exp_wave[k]) mism_v++;
      write = (k == 5);
    end
    write = 1'b0;
    chk("divchg_wave_mism", mism_v, 0);
    @(negedge clk);
    rd_chk("divchg_div", 8'hF2, 8'h01);

    // Reset in the middle of data bit 3 aborts the frame and the queue
    bus_write(8'hF2, 8'h03);
    bus_write(8'hF3, 8'h00);
    bus_write(8'hF0, 8'h00);
    bus_write(8'hF0, 8'h55);
    bus_write(8'hF3, 8'h01);
    to_v = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (tx === 1'b0) begin to_v = 1'b0; break; end
      @(negedge clk);
    end
    chk("rstmid_start_seen", to_v, 1'b0);
    for (int i = 0; i < 17; i++) @(negedge clk);
    chk("rstmid_tx_low_before", tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_tx", tx, 1'b1);
    chk("rstmid_irq", irq, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_irq_after", irq, 1'b1);
    rd_chk("rstmid_status", 8'hF1, 8'h04);
    rd_chk("rstmid_div", 8'hF2, 8'h09);
    rd_chk("rstmid_ctrl", 8'hF3, 8'h00);
    count_lows(100, lows_v);
    chk("rstmid_no_frames", lows_v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
